apb_req_arbiter: RTL

- Round-robin arbiter and APB master sequencer. Shares the single APB slave port of the peripheral subsystem between NUM_REQ requesters, e.g. the AXI-Lite bridge path and a debug/DMA master.
- Each requester issues a simple latched command (req/ack). The block selects one requester, runs the APB SETUP/ACCESS phases, and returns read data and error status to that requester only.
- Sits between the requesters and the periphery APB interface.

---
 rtl/apb_req_arbiter.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//
// Round-robin arbiter plus APB master sequencer. Shares one APB port between
// NUM_REQ requesters. Each requester raises req_i with its command fields
// held stable. The block grants one requester, runs the APB SETUP and ACCESS
// phases, and then returns a one-cycle ack_o pulse to that requester only,
// together with the read data and error status.
//
// Optional feature (macro APB_ARB_TIMEOUT_EN):
//   When the macro is defined, an ACCESS phase that lasts TIMEOUT_CYCLES
//   cycles with pready_i low is abandoned. The requester gets an error ack.
//   When the macro is undefined, ACCESS waits for pready_i with no limit.
//
// Parameters:
//   NUM_REQ        number of requesters (1..8)
//   APB_AW         APB address width
//   APB_DW         APB data width, must be a multiple of 8
//   TIMEOUT_CYCLES ACCESS-phase cycle limit (used only with APB_ARB_TIMEOUT_EN)
//
// Ports:
//   clk_i, rst_ni             clock and synchronous active-low reset
//   req_i / req_write_i       per-requester request and direction (1 = write)
//   req_addr_i, req_wdata_i,  packed per-requester command fields;
//   req_strb_i, req_prot_i    requester k occupies slice k of each vector
//   ack_o                     one-hot completion pulse, one cycle long
//   rsp_rdata_o, rsp_err_o    response; valid only while ack_o is nonzero
//   paddr_o .. pstrb_o        APB master outputs, all registered
//   pready_i, prdata_i,       APB slave responses
//   pslverr_i
// -----------------------------------------------------------------------------
module apb_req_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int APB_AW         = 32,
   parameter int APB_DW         = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NUM_REQ-1:0]          req_i,
   input  logic [NUM_REQ-1:0]          req_write_i,
   input  logic [NUM_REQ*APB_AW-1:0]   req_addr_i,
   input  logic [NUM_REQ*APB_DW-1:0]   req_wdata_i,
   input  logic [NUM_REQ*APB_DW/8-1:0] req_strb_i,
   input  logic [NUM_REQ*3-1:0]        req_prot_i,
   output logic [NUM_REQ-1:0]          ack_o,
   output logic [APB_DW-1:0]           rsp_rdata_o,
   output logic                        rsp_err_o,
   output logic [APB_AW-1:0]           paddr_o,
   output logic [2:0]                  pprot_o,
   output logic                        psel_o,
   output logic                        penable_o,
   output logic                        pwrite_o,
   output logic [APB_DW-1:0]           pwdata_o,
   output logic [APB_DW/8-1:0]         pstrb_o,
   input  logic                        pready_i,
   input  logic [APB_DW-1:0]           prdata_i,
   input  logic                        pslverr_i
);

   localparam int SW    = APB_DW / 8;
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;

   // ---------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------------
   if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
      $error("apb_req_arbiter: NUM_REQ must be in 1..8");
   end
   if (APB_DW < 8 || (APB_DW % 8) != 0) begin : g_bad_apb_dw
      $error("apb_req_arbiter: APB_DW must be a multiple of 8");
   end
`ifdef APB_ARB_TIMEOUT_EN
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("apb_req_arbiter: TIMEOUT_CYCLES must be at least 2");
   end
`else
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_req_arbiter: TIMEOUT_CYCLES must be positive");
   end
`endif

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [1:0]         state;
   logic [IDX_W-1:0]   last_gnt;
   logic [IDX_W-1:0]   gnt;

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] gnt_onehot;
   logic               grant_valid;
   logic [IDX_W-1:0]   grant_idx;
   logic [IDX_W-1:0]   cand;

   logic               sel_write;
   logic [APB_AW-1:0]  sel_addr;
   logic [APB_DW-1:0]  sel_wdata;
   logic [SW-1:0]      sel_strb;
   logic [2:0]         sel_prot;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TO_W-1:0]    to_cnt;
   logic               to_expired;

   assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

   // A requester being acked this cycle still has req_i high; masking it
   // keeps it from being granted again before it has seen the ack.
   assign eligible = req_i & ~ack_o;

   // Round-robin search. Candidates are visited from the farthest offset to
   // the nearest one, so the nearest eligible requester after last_gnt wins.
   // NOTE: every variable written in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = IDX_W'((int'(last_gnt) + i) % NUM_REQ);
         if (eligible[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Select the command fields of the requester that wins this cycle.
   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_strb  = '0;
      sel_prot  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (IDX_W'(k) == grant_idx) begin
            sel_write = req_write_i[k];
            sel_addr  = req_addr_i[k*APB_AW +: APB_AW];
            sel_wdata = req_wdata_i[k*APB_DW +: APB_DW];
            sel_strb  = req_strb_i[k*SW +: SW];
            sel_prot  = req_prot_i[k*3 +: 3];
         end
      end
   end

   // Decode the stored grant index to the one-hot ack vector.
   always_comb begin
      gnt_onehot = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (IDX_W'(k) == gnt) gnt_onehot[k] = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before the edge, whatever the statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state       <= S_IDLE;
         last_gnt    <= IDX_W'(NUM_REQ - 1);
         gnt         <= '0;
         ack_o       <= '0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
         paddr_o     <= '0;
         pprot_o     <= '0;
         psel_o      <= 1'b0;
         penable_o   <= 1'b0;
         pwrite_o    <= 1'b0;
         pwdata_o    <= '0;
         pstrb_o     <= '0;
`ifdef APB_ARB_TIMEOUT_EN
         to_cnt      <= '0;
`endif
      end else begin
         // The response lasts exactly one cycle.
         ack_o       <= '0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;

         case (state)
            S_IDLE: begin
               if (grant_valid) begin
                  gnt       <= grant_idx;
                  pwrite_o  <= sel_write;
                  paddr_o   <= sel_addr;
                  pwdata_o  <= sel_wdata;
                  pstrb_o   <= sel_strb;
                  pprot_o   <= sel_prot;
                  psel_o    <= 1'b1;
                  penable_o <= 1'b0;
                  state     <= S_SETUP;
               end
            end

            S_SETUP: begin
               penable_o <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
               to_cnt    <= '0;
`endif
               state     <= S_ACCESS;
            end

            S_ACCESS: begin
               if (pready_i) begin
                  psel_o      <= 1'b0;
                  penable_o   <= 1'b0;
                  ack_o       <= gnt_onehot;
                  rsp_err_o   <= pslverr_i;
                  rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
                  last_gnt    <= gnt;
                  state       <= S_IDLE;
               end
`ifdef APB_ARB_TIMEOUT_EN
               else if (to_expired) begin
                  // Abandon the transfer. A late pready_i finds the block
                  // in IDLE and is ignored.
                  psel_o    <= 1'b0;
                  penable_o <= 1'b0;
                  ack_o     <= gnt_onehot;
                  rsp_err_o <= 1'b1;
                  last_gnt  <= gnt;
                  state     <= S_IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end

            default: begin
               psel_o    <= 1'b0;
               penable_o <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
